// File: rtl/nfca_pkg.sv
// rtl/nfca_pkg.sv - shared NFC-A framer encodings, CRC_A preset and CRC_A byte update
package nfca_pkg;

    localparam logic [1:0] NFCA_MODE_STD     = 2'd0;
    localparam logic [1:0] NFCA_MODE_STD_CRC = 2'd1;
    localparam logic [1:0] NFCA_MODE_SHORT   = 2'd2;
    localparam logic [1:0] NFCA_MODE_BITS    = 2'd3;

    localparam logic [15:0] NFCA_CRC_A_INIT = 16'h6363;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_COLLECT,
        ST_SEND_S,
        ST_LOAD,
        ST_SHIFT,
        ST_CRC,
        ST_SEND_E,
        ST_DONE
    } tx_state_e;

    // Bitwise CRC_A update, reflected polynomial 0x8408, data LSB first.
    function automatic logic [15:0] crc16a(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/nfca_tx_buf.sv
// rtl/nfca_tx_buf.sv - 1R1W frame byte buffer with registered read port
module nfca_tx_buf #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/nfca_tx_framer.sv
// rtl/nfca_tx_framer.sv - NFC-A PCD frame builder: buffers one frame, serialises S/data/parity/CRC_A/E
module nfca_tx_framer
    import nfca_pkg::*;
#(
    parameter int          AW       = 12,
    parameter logic [15:0] CRC_INIT = NFCA_CRC_A_INIT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_tvalid,
    output logic       tx_tready,
    input  logic [7:0] tx_tdata,
    input  logic [3:0] tx_tdatab,
    input  logic       tx_tlast,
    input  logic [1:0] tx_mode,
    input  logic       abort,
    input  logic       tx_req,
    output logic       tx_en,
    output logic       tx_bit,
    output logic [2:0] remainb,
    output logic       busy,
    output logic       done,
    output logic       err_ovf
);

    tx_state_e   state, state_n;
    logic [AW:0]   wcnt, wcnt_n;
    logic [AW-1:0] rptr, rptr_n;
    logic          ovf, ovf_n;
    logic [15:0]   crc, crc_n;
    logic [3:0]    lastb, lastb_n;
    logic [1:0]    mode, mode_n;
    logic [17:0]   sr, sr_n;
    logic [4:0]    cnt, cnt_n;
    logic          in_crc, in_crc_n;
    logic          load_ph, load_ph_n;
    logic          tx_en_n, tx_bit_n, busy_n, done_n, err_ovf_n;
    logic [2:0]    remainb_n;

    logic          hs, full, ovf_all, last_byte, buf_we;
    logic [AW-1:0] last_idx;
    logic [3:0]    lastb_in;
    logic [7:0]    rdata;

    assign tx_tready = (state == ST_COLLECT);
    assign hs        = tx_tvalid && tx_tready;
    // wcnt counts stored bytes, so a full buffer is exactly wcnt == 2^AW
    assign full      = wcnt[AW];
    assign last_idx  = wcnt[AW-1:0] - AW'(1);
    assign last_byte = (rptr == last_idx);
    assign buf_we    = hs && !full && !abort;
    assign lastb_in  = (tx_tdatab == 4'd0) ? 4'd1 :
                       (tx_tdatab > 4'd8)  ? 4'd8 : tx_tdatab;

    nfca_tx_buf #(.AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wcnt[AW-1:0]),
        .wdata (tx_tdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        rptr_n    = rptr;
        ovf_n     = ovf;
        crc_n     = crc;
        lastb_n   = lastb;
        mode_n    = mode;
        sr_n      = sr;
        cnt_n     = cnt;
        in_crc_n  = in_crc;
        load_ph_n = load_ph;
        tx_en_n   = tx_en;
        tx_bit_n  = tx_bit;
        remainb_n = remainb;
        busy_n    = busy;
        done_n    = 1'b0;
        err_ovf_n = 1'b0;
        ovf_all   = ovf | full;

        if (abort) begin
            state_n   = ST_COLLECT;
            wcnt_n    = '0;
            rptr_n    = '0;
            ovf_n     = 1'b0;
            crc_n     = CRC_INIT;
            in_crc_n  = 1'b0;
            load_ph_n = 1'b0;
            tx_en_n   = 1'b0;
            tx_bit_n  = 1'b0;
            remainb_n = 3'd0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_INIT: state_n = ST_COLLECT;
                ST_COLLECT: begin
                    if (hs) begin
                        crc_n   = crc16a(crc, tx_tdata);
                        lastb_n = lastb_in;
                        ovf_n   = ovf_all;
                        if (!full) begin
                            wcnt_n = wcnt + (AW+1)'(1);
                        end
                        if (tx_tlast) begin
                            if (ovf_all) begin
                                err_ovf_n = 1'b1;
                                wcnt_n    = '0;
                                crc_n     = CRC_INIT;
                                ovf_n     = 1'b0;
                            end else begin
                                mode_n  = tx_mode;
                                busy_n  = 1'b1;
                                rptr_n  = '0;
                                state_n = ST_SEND_S;
                            end
                        end
                    end
                end
                ST_SEND_S: begin
                    if (tx_req) begin
                        tx_en_n   = 1'b1;
                        tx_bit_n  = 1'b0;
                        load_ph_n = 1'b0;
                        state_n   = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // first cycle lets the RAM register the byte at the freshly updated rptr
                    if (!load_ph) begin
                        load_ph_n = 1'b1;
                    end else begin
                        load_ph_n = 1'b0;
                        state_n   = ST_SHIFT;
                        remainb_n = 3'd0;
                        if (mode == NFCA_MODE_SHORT) begin
                            sr_n  = {11'd0, rdata[6:0]};
                            cnt_n = 5'd7;
                        end else if (mode == NFCA_MODE_BITS && last_byte && lastb < 4'd8) begin
                            sr_n      = {10'd0, rdata};
                            cnt_n     = {1'b0, lastb};
                            remainb_n = lastb[2:0];
                        end else begin
                            sr_n  = {9'd0, ~^rdata, rdata};
                            cnt_n = 5'd9;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tx_req) begin
                        tx_en_n  = 1'b1;
                        tx_bit_n = sr[0];
                        sr_n     = sr >> 1;
                        cnt_n    = cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            if (in_crc) begin
                                in_crc_n = 1'b0;
                                state_n  = ST_SEND_E;
                            end else if (mode == NFCA_MODE_SHORT || last_byte) begin
                                state_n = (mode == NFCA_MODE_STD_CRC) ? ST_CRC : ST_SEND_E;
                            end else begin
                                rptr_n  = rptr + AW'(1);
                                state_n = ST_LOAD;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    sr_n     = {~^crc[15:8], crc[15:8], ~^crc[7:0], crc[7:0]};
                    cnt_n    = 5'd18;
                    in_crc_n = 1'b1;
                    state_n  = ST_SHIFT;
                end
                ST_SEND_E: begin
                    if (tx_req) begin
                        tx_en_n  = 1'b1;
                        tx_bit_n = 1'b0;
                        state_n  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (tx_req) begin
                        tx_en_n  = 1'b0;
                        tx_bit_n = 1'b0;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        wcnt_n   = '0;
                        rptr_n   = '0;
                        ovf_n    = 1'b0;
                        crc_n    = CRC_INIT;
                        state_n  = ST_COLLECT;
                    end
                end
                default: state_n = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_INIT;
            wcnt    <= '0;
            rptr    <= '0;
            ovf     <= 1'b0;
            crc     <= CRC_INIT;
            lastb   <= 4'd8;
            mode    <= NFCA_MODE_STD;
            sr      <= '0;
            cnt     <= '0;
            in_crc  <= 1'b0;
            load_ph <= 1'b0;
            tx_en   <= 1'b0;
            tx_bit  <= 1'b0;
            remainb <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            rptr    <= rptr_n;
            ovf     <= ovf_n;
            crc     <= crc_n;
            lastb   <= lastb_n;
            mode    <= mode_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            in_crc  <= in_crc_n;
            load_ph <= load_ph_n;
            tx_en   <= tx_en_n;
            tx_bit  <= tx_bit_n;
            remainb <= remainb_n;
            busy    <= busy_n;
            done    <= done_n;
            err_ovf <= err_ovf_n;
        end
    end

endmodule
